outcome_reader: RTL and testbench
=================================

Name: outcome_reader

Overview:
- Read-side counterpart of the result serializer that fills the outcome SRAM.
- On `start`, reads `ARRAY_SIZE` consecutive 32-bit result words from the outcome SRAM through its read port.
- Streams the words out on a valid/ready interface, with a `last` flag on the final word.
- Sits between `sram_outcome_inst` and the host/DMA side, and is launched after the top-level `processing_done`.

Parameters:
- ARRAY_SIZE, 32, number of words read per transaction.
- DATA_WIDTH, 32, width of an SRAM word and of the stream data.
- ADDR_WIDTH, $clog2(ARRAY_SIZE), outcome SRAM address width.
- FIFO_DEPTH, 2, output buffer entries that absorb SRAM read latency and backpressure.

Ports:
- clk  input  1  single clock; all logic on posedge.
- srstn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle launch request; honoured only in IDLE.
- base_addr  input  ADDR_WIDTH  first SRAM address; sampled when start is accepted.
- sram_csb  output  1  outcome SRAM chip select, active low; low = read issued this cycle.
- sram_raddr  output  ADDR_WIDTH  outcome SRAM read address.
- sram_rdata  input  DATA_WIDTH  SRAM read data, valid the cycle after a read is issued.
- m_valid  output  1  stream word valid.
- m_data  output  DATA_WIDTH  stream word.
- m_last  output  1  high with the final (ARRAY_SIZE-th) word.
- m_ready  input  1  sink accepts the word when m_valid && m_ready.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse after the last word handshake.

Behaviour:
- Reset values: sram_csb=1, sram_raddr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0. FIFO is emptied, the counters are cleared and the FSM returns to IDLE. Reset asserted mid-transaction aborts immediately; no words are emitted after srstn deasserts.
- FSM states:
  - IDLE: on start, latch base_addr, clear rd_cnt and out_cnt, set busy, go to READ.
  - READ: issue reads until rd_cnt==ARRAY_SIZE, then go to DRAIN.
  - DRAIN: wait until out_cnt==ARRAY_SIZE, then go to FIN.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- Read issue rule, in READ: issue when (fifo_count + inflight − pop) < FIFO_DEPTH and rd_cnt < ARRAY_SIZE.
  - pop = m_valid && m_ready this cycle.
  - inflight = a read was issued last cycle.
  - On issue: sram_csb=0, sram_raddr = base_addr + rd_cnt, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH); rd_cnt increments.
- Capture: sram_rdata is pushed into the FIFO the cycle after issue. The FIFO can never overflow; an overflow is a design bug (assertion).
- Output: m_valid = FIFO non-empty; m_data = FIFO head; m_last = (out_cnt == ARRAY_SIZE−1) && m_valid. m_data and m_valid stay stable while m_valid && !m_ready. out_cnt increments on each handshake.
- Latency: start sampled at cycle 0 → sram_csb low at cycle 1 → rdata at cycle 2 → m_valid at cycle 3. With m_ready held high there is one word per cycle; the last word appears at cycle ARRAY_SIZE+2 and done pulses at cycle ARRAY_SIZE+3.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- start while busy is ignored; it has no effect on any counter.
- start in the FIN cycle is ignored; the block is idle only from the following cycle.
- Counter widths are $clog2(ARRAY_SIZE+1) bits.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, READ, DRAIN, FIN).
  - DATA_WIDTH/ARRAY_SIZE defaults, matching the PE core and write-out.
- Sub-module: `sync_fifo` (parameters DATA_WIDTH and FIFO_DEPTH; push/pop/full/empty/count outputs), reusable elsewhere in the accelerator.
- Issue control, FSM and counters stay in `outcome_reader`.

Test Plan:
- Full-rate read: SRAM preloaded with word i = 0x3F800000+i, base_addr=0, m_ready=1, start at cycle 0 → 32 words 0x3F800000..0x3F80001F on cycles 3..34, m_last only at 0x3F80001F, done at cycle 35, busy 1..34.
- Backpressure: m_ready low for cycles 3–10, then alternating 1/0 → every word delivered once and in order. m_data stays stable while stalled. sram_csb is never low when FIFO count + inflight would exceed 2. done follows the 32nd handshake.
- Address wrap: ARRAY_SIZE=32, ADDR_WIDTH=5, base_addr=30 → read addresses 30, 31, 0, 1, …, 29; output order matches.
- start while busy: second start pulse at cycle 10 → no restart, counters unaffected, exactly 32 words and a single done.
- Reset mid-transfer: srstn low at cycle 15 with m_ready=0 (FIFO full) → all outputs return to reset values asynchronously, FIFO empties. A new start after release yields a clean 32-word transfer starting from word 0.
- Back-to-back: start asserted in the cycle after done → second transaction begins normally, first m_valid 3 cycles later.

Source files
------------

// File: rtl/outcome_reader_pkg.sv
// Shared definitions for the outcome-SRAM read-out path: default sizes and FSM encoding.
package outcome_reader_pkg;

  localparam int DEF_ARRAY_SIZE = 32;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_FIN
  } rd_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO; a push and a pop in the same cycle on a full FIFO is legal.
module sync_fifo #(
  parameter  int DATA_WIDTH = 32,
  parameter  int FIFO_DEPTH = 2,
  localparam int CW         = $clog2(FIFO_DEPTH + 1),
  localparam int PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         cnt_q;
  logic                  do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign count   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // A dropped push would silently lose a word; the producer must never let this happen.
  a_no_overflow: assert property (@(posedge clk) disable iff (!srstn) !(push && full && !pop));

endmodule

// File: rtl/outcome_reader.sv
// Reads ARRAY_SIZE words from the outcome SRAM and streams them out with valid/ready/last.
module outcome_reader
  import outcome_reader_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = $clog2(ARRAY_SIZE),
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  sram_csb,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int CNTW = $clog2(ARRAY_SIZE + 1);
  localparam int FCW  = $clog2(FIFO_DEPTH + 1);
  localparam int OCCW = FCW + 1;

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNTW-1:0]       rd_cnt_q, rd_cnt_d;
  logic [CNTW-1:0]       out_cnt_q, out_cnt_d;
  logic                  inflight_q;

  logic                  pop, issue;
  logic                  fifo_empty, fifo_full;
  logic [FCW-1:0]        fifo_count;
  logic [OCCW-1:0]       occ;

  // Slots already committed (stored + in flight) after this cycle's pop; issue only if one is left.
  assign pop   = m_valid && m_ready;
  assign occ   = OCCW'(fifo_count) + OCCW'(inflight_q) - OCCW'(pop);
  assign issue = (state_q == ST_READ) && (rd_cnt_q < CNTW'(ARRAY_SIZE))
              && (occ < OCCW'(FIFO_DEPTH));

  assign sram_csb   = !issue;
  assign sram_raddr = base_q + ADDR_WIDTH'(rd_cnt_q);
  assign m_valid    = !fifo_empty;
  assign m_last     = m_valid && (out_cnt_q == CNTW'(ARRAY_SIZE - 1));
  assign busy       = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_FIN);

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .srstn (srstn),
    .push  (inflight_q),
    .din   (sram_rdata),
    .pop   (pop),
    .dout  (m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    rd_cnt_d  = rd_cnt_q;
    out_cnt_d = out_cnt_q;
    if (issue) rd_cnt_d = rd_cnt_q + 1'b1;
    if (pop)   out_cnt_d = out_cnt_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d    = base_addr;
          rd_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = ST_READ;
        end
      end
      ST_READ:  if (rd_cnt_d == CNTW'(ARRAY_SIZE)) state_d = ST_DRAIN;
      // Leave on the final handshake itself so done lands one cycle after it.
      ST_DRAIN: if (out_cnt_d == CNTW'(ARRAY_SIZE)) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= issue;
    end
  end

  a_issue_room: assert property (@(posedge clk) disable iff (!srstn)
    !(inflight_q && fifo_full && !pop));

endmodule

// File: tb/tb_outcome_reader.sv
// Directed bench for outcome_reader: vector table of transactions plus reset/FIN corner sequences.
module tb_outcome_reader;

  localparam int N  = 32;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [31:0] WBASE = 32'h3F80_0000;

  logic          clk = 1'b0;
  logic          srstn, start, m_ready;
  logic [AW-1:0] base_addr;
  logic          sram_csb;
  logic [AW-1:0] sram_raddr;
  logic [DW-1:0] sram_rdata;
  logic          m_valid, m_last, busy, done;
  logic [DW-1:0] m_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  outcome_reader #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .srstn      (srstn),
    .start      (start),
    .base_addr  (base_addr),
    .sram_csb   (sram_csb),
    .sram_raddr (sram_raddr),
    .sram_rdata (sram_rdata),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done)
  );

  logic [DW-1:0] mem [N];
  always @(posedge clk) if (!sram_csb) sram_rdata <= mem[sram_raddr];

  typedef struct {
    logic [AW-1:0] base;
    int            mode;          // 0: ready always, 1: stalled 3..10 then alternating
    int            second_start;  // window of an extra start pulse, -1 for none
    bit            start_at_done;
    int            exp_first;
    int            exp_done;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic ready_for(input int mode, input int w);
    if (mode == 0 || w < 3) return 1'b1;
    if (w <= 10) return 1'b0;
    return ((w - 11) % 2) == 0;
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] b, input int k);
    return b + AW'(k);
  endfunction

  task automatic run_txn(input vec_t v);
    int hs, iss, tcnt, tinf, occ;
    logic pstall, pop;
    logic [DW-1:0] pd;
    hs = 0; iss = 0; tcnt = 0; tinf = 0; pstall = 1'b0; pd = '0;
    for (int w = 0; w <= v.exp_done; w++) begin
      @(posedge clk); #1;
      start     = (w == 0) || (w == v.second_start) || (v.start_at_done && w == v.exp_done);
      base_addr = (w == 0) ? v.base : v.base + 5'd7;
      m_ready   = ready_for(v.mode, w);
      @(negedge clk);
      pop = m_valid && m_ready;
      chk("valid_vs_model", m_valid, tcnt != 0);
      if (w == v.exp_first - 1) chk("no_early_valid", m_valid, 1'b0);
      if (w == v.exp_first)     chk("first_valid", m_valid, 1'b1);
      if (pstall) begin
        chk("stall_valid", m_valid, 1'b1);
        chk("stall_data", m_data, pd);
      end
      if (!sram_csb) begin
        occ = tcnt + tinf - int'(pop);
        chk("raddr", sram_raddr, addr_of(v.base, iss));
        chk("occupancy_ok", occ < 2, 1'b1);
        iss++;
      end
      if (pop) begin
        chk("data", m_data, WBASE + 32'(addr_of(v.base, hs)));
        chk("last", m_last, hs == N - 1);
        hs++;
      end else if (m_valid) begin
        chk("last_stalled", m_last, hs == N - 1);
      end
      chk("busy", busy, (w >= 1) && (w < v.exp_done));
      chk("done", done, w == v.exp_done);
      tcnt   = tcnt + tinf - int'(pop);
      tinf   = !sram_csb;
      pstall = m_valid && !m_ready;
      pd     = m_data;
    end
    chk("words_delivered", hs, N);
    chk("reads_issued", iss, N);
  endtask

  task automatic check_idle(input string nm);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_csb"}, sram_csb, 1'b1);
    chk({nm, "_valid"}, m_valid, 1'b0);
    chk({nm, "_done"}, done, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = WBASE + 32'(i);
    vecs[0] = '{5'd0,  0, -1, 1'b0, 3, 35};
    vecs[1] = '{5'd0,  1, -1, 1'b0, 3, 74};
    vecs[2] = '{5'd30, 0, -1, 1'b0, 3, 35};
    vecs[3] = '{5'd30, 1, -1, 1'b0, 3, 74};
    vecs[4] = '{5'd0,  0, 10, 1'b0, 3, 35};
    vecs[5] = '{5'd5,  0, -1, 1'b1, 3, 35};

    srstn = 1'b0; start = 1'b0; m_ready = 1'b1; base_addr = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_csb", sram_csb, 1'b1);
    chk("rst_raddr", sram_raddr, '0);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_data", m_data, '0);
    chk("rst_last", m_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(posedge clk); #1;
    srstn = 1'b1;

    // Vectors run back to back: each starts in the cycle right after the previous done.
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i]);
      if (vecs[i].start_at_done)
        for (int k = 0; k < 3; k++) check_idle("fin_start");
    end

    // Abort with the FIFO full and the sink stalled.
    for (int w = 0; w <= 15; w++) begin
      @(posedge clk); #1;
      start     = (w == 0);
      base_addr = '0;
      m_ready   = 1'b0;
      if (w == 14) begin
        @(negedge clk);
        chk("pre_rst_valid", m_valid, 1'b1);
        chk("pre_rst_data", m_data, WBASE);
        chk("pre_rst_busy", busy, 1'b1);
      end else if (w == 15) begin
        srstn = 1'b0;
        #1;
        chk("mid_rst_csb", sram_csb, 1'b1);
        chk("mid_rst_raddr", sram_raddr, '0);
        chk("mid_rst_valid", m_valid, 1'b0);
        chk("mid_rst_data", m_data, '0);
        chk("mid_rst_last", m_last, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
      end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    srstn = 1'b1;
    for (int k = 0; k < 2; k++) check_idle("post_rst");
    run_txn(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
